// File: rtl/conv1x1_scheduler_pkg.sv
// Shared constants, types and helpers for the 1x1-convolution scheduler:
// geometry, weight-word field layout, FSM encoding and the result/tag record.
package conv1x1_scheduler_pkg;

   localparam int IN_CHANNEL  = 20;
   localparam int OUT_CHANNEL = 16;
   localparam int PIX_W       = 12;
   localparam int PE_LATENCY  = 5;
   localparam int FIFO_DEPTH  = 8;

   localparam int OC_W       = $clog2(OUT_CHANNEL);
   localparam int VEC_W      = 8 * IN_CHANNEL;
   localparam int KERNEL_LSB = 0;
   localparam int COEFF_LSB  = 8 * IN_CHANNEL;
   localparam int BIAS_LSB   = COEFF_LSB + 16;
   localparam int WGT_W      = BIAS_LSB + 32;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int GUARD_W    = $clog2(PE_LATENCY + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_LATCH = 3'd2,
      ST_RUN   = 3'd3,
      ST_DRAIN = 3'd4,
      ST_FIN   = 3'd5
   } state_e;

   typedef struct packed {
      logic [7:0]       data;
      logic [PIX_W-1:0] pix;
      logic [OC_W-1:0]  oc;
   } result_t;

   // An op may issue only if its result is guaranteed a FIFO slot: every
   // queued entry and every op still inside the PE already owns one.
   function automatic logic credit_avail(input logic [CNT_W-1:0] fifo_count,
                                         input logic [CNT_W-1:0] in_flight);
      logic [CNT_W:0] used;
      used = {1'b0, fifo_count} + {1'b0, in_flight};
      return used < (CNT_W + 1)'(FIFO_DEPTH);
   endfunction

endpackage

// File: rtl/conv1x1_scheduler_if.sv
// Bundle of all scheduler-facing signals: layer control, feature/weight memory
// read ports, PE issue/return ports and the tagged output stream.
// slave = scheduler view, master = environment view.
interface conv1x1_scheduler_if;
   import conv1x1_scheduler_pkg::*;

   logic                     start;
   logic [PIX_W-1:0]         num_pixels;
   logic                     busy;
   logic                     done;

   logic                     fmap_rd_en;
   logic [PIX_W-1:0]         fmap_rd_addr;
   logic [VEC_W-1:0]         fmap_rd_data;

   logic                     wgt_rd_en;
   logic [OC_W-1:0]          wgt_rd_addr;
   logic [WGT_W-1:0]         wgt_rd_data;

   logic                     pe_input_ready;
   logic [VEC_W-1:0]         pe_input_data;
   logic [VEC_W-1:0]         pe_kernel_data;
   logic [15:0]              pe_coeff;
   logic signed [31:0]       pe_bias;
   logic [7:0]               pe_output_data;
   logic                     pe_output_valid;

   logic                     out_valid;
   logic                     out_ready;
   logic [7:0]               out_data;
   logic [PIX_W-1:0]         out_pixel;
   logic [OC_W-1:0]          out_channel;

   logic                     err_overflow;

   modport slave (
      input  start, num_pixels, fmap_rd_data, wgt_rd_data,
             pe_output_data, pe_output_valid, out_ready,
      output busy, done, fmap_rd_en, fmap_rd_addr, wgt_rd_en, wgt_rd_addr,
             pe_input_ready, pe_input_data, pe_kernel_data, pe_coeff, pe_bias,
             out_valid, out_data, out_pixel, out_channel, err_overflow
   );

   modport master (
      output start, num_pixels, fmap_rd_data, wgt_rd_data,
             pe_output_data, pe_output_valid, out_ready,
      input  busy, done, fmap_rd_en, fmap_rd_addr, wgt_rd_en, wgt_rd_addr,
             pe_input_ready, pe_input_data, pe_kernel_data, pe_coeff, pe_bias,
             out_valid, out_data, out_pixel, out_channel, err_overflow
   );

endinterface

// File: rtl/conv1x1_scheduler_sync_fifo.sv
// Small synchronous FIFO holding PE results with their pixel/channel tags.
// A push into a full FIFO is dropped unless a pop frees the slot that cycle.
module sync_fifo
   import conv1x1_scheduler_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  result_t                 wdata,
   output result_t                 rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);

   result_t         mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW + 1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset since occupancy guards reads.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/conv1x1_scheduler.sv
// Walks a feature map pixel by pixel, issuing one PE op per output channel,
// gating issue on output-FIFO credit and tagging returning results.
module conv1x1_scheduler
   import conv1x1_scheduler_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   conv1x1_scheduler_if.slave bus
);

   state_e              state;
   logic                busy_q;
   logic                done_q;
   logic [PIX_W-1:0]    num_pix;
   logic [PIX_W-1:0]    pix;
   logic [OC_W-1:0]     oc;
   logic [VEC_W-1:0]    pixel_hold;

   logic                issue_p0;
   logic                vld_p1;

   logic [CNT_W-1:0]    in_flight;
   logic [CNT_W-1:0]    fifo_count;
   logic [GUARD_W-1:0]  guard;
   logic                err_q;
   logic [PIX_W-1:0]    wr_pix;
   logic [OC_W-1:0]     wr_oc;

   logic                result_ok;
   logic                stray_result;
   logic                pop;
   logic                full;
   logic                empty;
   result_t             push_word;
   result_t             head;

   // ---- stage p0: weight fetch, gated by credit
   assign issue_p0 = (state == ST_RUN) && credit_avail(fifo_count, in_flight);

   // A result is only trusted outside the post-reset window and when some op
   // is actually outstanding; anything else is a stray strobe.
   assign result_ok    = bus.pe_output_valid && (guard == '0) && (in_flight != '0);
   assign stray_result = bus.pe_output_valid && (guard == '0) && (in_flight == '0);
   assign pop          = !empty && bus.out_ready;
   assign push_word    = '{data: bus.pe_output_data, pix: wr_pix, oc: wr_oc};

   // Layer sequencing: fetch pixel, latch it, sweep all channels, drain, finish.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         num_pix <= '0;
         pix     <= '0;
         oc      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (done_q) busy_q <= 1'b0;
               if (bus.start) begin
                  busy_q  <= 1'b1;
                  num_pix <= bus.num_pixels;
                  pix     <= '0;
                  oc      <= '0;
                  state   <= (bus.num_pixels != '0) ? ST_LOAD : ST_FIN;
               end
            end
            ST_LOAD: begin
               state <= ST_LATCH;
            end
            ST_LATCH: begin
               oc    <= '0;
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (issue_p0) begin
                  oc <= oc + 1'b1;
                  if (oc == OC_W'(OUT_CHANNEL - 1)) begin
                     if (({1'b0, pix} + (PIX_W + 1)'(1)) < {1'b0, num_pix}) begin
                        pix   <= pix + 1'b1;
                        state <= ST_LOAD;
                     end else begin
                        state <= ST_DRAIN;
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (in_flight == '0 && fifo_count == '0) state <= ST_FIN;
            end
            ST_FIN: begin
               done_q <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Pixel vector holding register; only rewritten in LATCH, after the last
   // op of the previous pixel has already been presented to the PE.
   always_ff @(posedge clk) begin
      if (state == ST_LATCH) pixel_hold <= bus.fmap_rd_data;
   end

   // ---- stage p1: PE issue strobe, aligned with the weight read data
   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= issue_p0;
   end

   // Return-side accounting: in-flight count, result tags, error flag and the
   // blanking window that swallows strobes from ops issued before a reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_flight <= '0;
         guard     <= GUARD_W'(PE_LATENCY);
         err_q     <= 1'b0;
         wr_pix    <= '0;
         wr_oc     <= '0;
      end else begin
         if (guard != '0) guard <= guard - 1'b1;

         case ({issue_p0, result_ok})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: in_flight <= in_flight;
         endcase

         if (stray_result || (result_ok && full && !pop)) err_q <= 1'b1;

         if (state == ST_IDLE && bus.start) begin
            wr_pix <= '0;
            wr_oc  <= '0;
         end else if (result_ok) begin
            if (wr_oc == OC_W'(OUT_CHANNEL - 1)) begin
               wr_oc  <= '0;
               wr_pix <= wr_pix + 1'b1;
            end else begin
               wr_oc  <= wr_oc + 1'b1;
            end
         end
      end
   end

   sync_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (result_ok),
      .pop   (pop),
      .wdata (push_word),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.fmap_rd_en     = (state == ST_LOAD);
   assign bus.fmap_rd_addr   = pix;
   assign bus.wgt_rd_en      = issue_p0;
   assign bus.wgt_rd_addr    = oc;
   assign bus.pe_input_ready = vld_p1;
   assign bus.pe_input_data  = pixel_hold;
   assign bus.pe_kernel_data = bus.wgt_rd_data[KERNEL_LSB +: VEC_W];
   assign bus.pe_coeff       = bus.wgt_rd_data[COEFF_LSB +: 16];
   assign bus.pe_bias        = signed'(bus.wgt_rd_data[BIAS_LSB +: 32]);
   assign bus.out_valid      = !empty;
   assign bus.out_data       = head.data;
   assign bus.out_pixel      = head.pix;
   assign bus.out_channel    = head.oc;
   assign bus.err_overflow   = err_q;

endmodule
